// File: rtl/nes_pkg.sv
// Shared types and constants for the NES pad poll controller.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_DONE
  } nes_poll_state_t;

  localparam int NES_NUM_BITS = 8;
  localparam int PHASE_W      = 8;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_phase_timer.sv
// Loadable down-counter; 'last' is high while the count sits at zero.
module nes_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/nes_poll_controller.sv
// NES pad read sequencer: latch, 7 clock pulses, 8 sampled bits, one valid pulse.
// Optional auto-poll timer enabled by defining NES_POLL_TIMER_EN.
module nes_poll_controller
  import nes_pkg::*;
#(
  parameter int          LATCH_CYCLES = 12,
  parameter int          HALF_CYCLES  = 6,
  parameter logic [15:0] POLL_PERIOD  = 16'd50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    poll_req,
  input  logic                    nes_data,
  output logic                    nes_latch,
  output logic                    nes_clk,
  output logic                    busy,
  output logic [NES_NUM_BITS-1:0] buttons,
  output logic                    buttons_valid
);

  if (LATCH_CYCLES < 3 || HALF_CYCLES < 3 || POLL_PERIOD == 16'd0) begin : g_param_check
    $error("nes_poll_controller: LATCH_CYCLES/HALF_CYCLES must be >= 3 and POLL_PERIOD nonzero");
  end

  nes_poll_state_t         state;
  logic                    d_meta;
  logic                    ds;
  logic [2:0]              idx;
  logic [NES_NUM_BITS-1:0] shadow;
  logic                    start;
  logic                    tmr_load;
  logic [PHASE_W-1:0]      tmr_val;
  logic                    tmr_last;

`ifdef NES_POLL_TIMER_EN
  logic [15:0] poll_cnt;
  logic        auto_req;

  // Free-running; a request landing mid-read is simply not seen by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt <= '0;
      auto_req <= 1'b0;
    end else if (poll_cnt == POLL_PERIOD - 16'd1) begin
      poll_cnt <= '0;
      auto_req <= 1'b1;
    end else begin
      poll_cnt <= poll_cnt + 16'd1;
      auto_req <= 1'b0;
    end
  end

  assign start = poll_req | auto_req;
`else
  assign start = poll_req;
`endif

  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = PHASE_W'(HALF_CYCLES - 1);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          tmr_load = 1'b1;
          tmr_val  = PHASE_W'(LATCH_CYCLES - 1);
        end
      end
      ST_LATCH, ST_CLK_HI: tmr_load = tmr_last;
      ST_CLK_LO:           tmr_load = tmr_last && (idx != 3'(BTN_RIGHT));
      default:             tmr_load = 1'b0;
    endcase
  end

  nes_phase_timer #(.W(PHASE_W)) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  // DONE doubles as the one-cycle idle gap, so a held request restarts from it.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_meta        <= 1'b0;
      ds            <= 1'b0;
      state         <= ST_IDLE;
      idx           <= '0;
      shadow        <= '0;
      nes_latch     <= 1'b0;
      nes_clk       <= 1'b0;
      busy          <= 1'b0;
      buttons       <= '0;
      buttons_valid <= 1'b0;
    end else begin
      d_meta        <= nes_data;
      ds            <= d_meta;
      buttons_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_LATCH;
            nes_latch <= 1'b1;
            busy      <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_LATCH: begin
          if (tmr_last) begin
            shadow[BTN_A] <= ~ds;
            idx           <= 3'd1;
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b1;
            state         <= ST_CLK_HI;
          end
        end
        ST_CLK_HI: begin
          if (tmr_last) begin
            nes_clk <= 1'b0;
            state   <= ST_CLK_LO;
          end
        end
        ST_CLK_LO: begin
          if (tmr_last) begin
            shadow[idx] <= ~ds;
            if (idx == 3'(BTN_RIGHT)) begin
              buttons       <= {~ds, shadow[NES_NUM_BITS-2:0]};
              buttons_valid <= 1'b1;
              busy          <= 1'b0;
              state         <= ST_DONE;
            end else begin
              idx     <= idx + 3'd1;
              nes_clk <= 1'b1;
              state   <= ST_CLK_HI;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
